// File: rtl/xversat_ctrl.sv
// Versat run/configuration controller: CPU bus decode into per-FU config strobes,
// control register bank, queued single-cycle run launches with done aggregation.
module xversat_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int N_FU      = 2,
    parameter int FU_ADDR_W = 8,
    parameter int Q_DEPTH   = 4,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic                 wstrb_i,
    input  logic [DATA_W-1:0]    wdata_i,
    output logic                 ready_o,
    output logic [DATA_W-1:0]    rdata_o,
    output logic [N_FU-1:0]      fu_valid_o,
    output logic [FU_ADDR_W-1:0] fu_addr_o,
    output logic [DATA_W-1:0]    fu_wdata_o,
    output logic                 fu_wstrb_o,
    output logic                 fu_run_o,
    output logic                 fu_clear_o,
    input  logic [N_FU-1:0]      fu_done_i,
    output logic                 irq_o
);

    // state   | meaning
    // IDLE    | no run active; pops a pending run when one is queued
    // LAUNCH  | fu_run asserted, cycle counter holds 1
    // GUARD   | FUs are still dropping done from the previous run; done ignored
    // WAIT    | counting until every unmasked FU reports done

    localparam int SEL_W = (N_FU > 1) ? $clog2(N_FU) : 1;
    localparam int QC_W  = $clog2(Q_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_GUARD,
        S_WAIT
    } state_t;

    localparam logic [2:0] REG_RUN    = 3'd0;
    localparam logic [2:0] REG_CLEAR  = 3'd1;
    localparam logic [2:0] REG_MASK   = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_CYCLES = 3'd4;
    localparam logic [2:0] REG_RUNS   = 3'd5;

    logic                 ready_q;
    logic [DATA_W-1:0]    rdata_q;
    logic [N_FU-1:0]      fu_valid_q;
    logic [FU_ADDR_W-1:0] fu_addr_q;
    logic [DATA_W-1:0]    fu_wdata_q;
    logic                 fu_wstrb_q;
    logic                 fu_clear_q;
    logic [N_FU-1:0]      mask_q;

    state_t               state_q;
    logic [QC_W-1:0]      pend_q;
    logic                 ovf_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cycles_last_q;
    logic [CNT_W-1:0]     runs_q;
    logic                 fu_run_q;
    logic                 irq_q;

    logic                 accept;
    logic                 ctrl_sel;
    logic [SEL_W-1:0]     fu_sel;
    logic [2:0]           reg_sel;
    logic                 fu_hit;
    logic [N_FU-1:0]      fu_onehot;
    logic                 run_wr;
    logic                 clr_wr;
    logic                 mask_wr;
    logic                 pend_full;
    logic                 push;
    logic                 pop;
    logic                 all_done;
    logic [DATA_W-1:0]    status_w;
    logic [DATA_W-1:0]    rd_d;
    logic                 unused_addr;

    assign accept   = valid_i & ~ready_q;
    assign ctrl_sel = addr_i[ADDR_W-1];
    assign fu_sel   = addr_i[ADDR_W-2 -: SEL_W];
    assign reg_sel  = addr_i[2:0];

    // Out-of-range selects still get acknowledged, they just strobe nothing.
    assign fu_hit = accept & ~ctrl_sel & (int'(fu_sel) < N_FU);

    always_comb begin
        fu_onehot = '0;
        for (int i = 0; i < N_FU; i++) begin
            if (int'(fu_sel) == i) fu_onehot[i] = 1'b1;
        end
    end

    assign run_wr  = accept & ctrl_sel & wstrb_i & (reg_sel == REG_RUN);
    assign clr_wr  = accept & ctrl_sel & wstrb_i & (reg_sel == REG_CLEAR);
    assign mask_wr = accept & ctrl_sel & wstrb_i & (reg_sel == REG_MASK);

    assign pend_full = (pend_q == QC_W'(Q_DEPTH));
    assign push      = run_wr & ~pend_full;
    assign pop       = (state_q == S_IDLE) & (pend_q != '0);
    assign all_done  = &(fu_done_i | ~mask_q);

    assign unused_addr = ^addr_i;

    always_comb begin
        status_w              = '0;
        status_w[0]           = (state_q == S_IDLE) && (pend_q == '0);
        status_w[1]           = (state_q != S_IDLE);
        status_w[2]           = ovf_q;
        status_w[8 +: QC_W]   = pend_q;
        status_w[16 +: N_FU]  = fu_done_i;
    end

    always_comb begin
        rd_d = '0;
        if (ctrl_sel) begin
            case (reg_sel)
                REG_MASK:   rd_d[N_FU-1:0]  = mask_q;
                REG_STATUS: rd_d            = status_w;
                REG_CYCLES: rd_d[CNT_W-1:0] = cycles_last_q;
                REG_RUNS:   rd_d[CNT_W-1:0] = runs_q;
                default:    rd_d            = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            fu_valid_q <= '0;
            fu_addr_q  <= '0;
            fu_wdata_q <= '0;
            fu_wstrb_q <= 1'b0;
            fu_clear_q <= 1'b0;
            mask_q     <= '1;
        end else begin
            ready_q    <= accept;
            rdata_q    <= (accept & ~wstrb_i) ? rd_d : '0;
            fu_valid_q <= fu_hit ? fu_onehot : '0;
            fu_wstrb_q <= fu_hit & wstrb_i;
            fu_clear_q <= clr_wr;
            if (fu_hit) begin
                fu_addr_q  <= addr_i[FU_ADDR_W-1:0];
                fu_wdata_q <= wdata_i;
            end
            if (mask_wr) mask_q <= wdata_i[N_FU-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pend_q        <= '0;
            ovf_q         <= 1'b0;
            cnt_q         <= '0;
            cycles_last_q <= '0;
            runs_q        <= '0;
            fu_run_q      <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            fu_run_q <= 1'b0;
            irq_q    <= 1'b0;
            // Clear wins over any enqueue, pop or completion in the same cycle.
            if (clr_wr) begin
                state_q <= S_IDLE;
                pend_q  <= '0;
                ovf_q   <= 1'b0;
            end else begin
                if (run_wr & pend_full) ovf_q <= 1'b1;
                pend_q <= pend_q + QC_W'(push) - QC_W'(pop);
                case (state_q)
                    S_IDLE: begin
                        if (pop) begin
                            state_q  <= S_LAUNCH;
                            fu_run_q <= 1'b1;
                            cnt_q    <= CNT_W'(1);
                        end
                    end
                    S_LAUNCH: begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state_q <= S_GUARD;
                    end
                    S_GUARD: begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (all_done) begin
                            cycles_last_q <= cnt_q;
                            runs_q        <= runs_q + CNT_W'(1);
                            irq_q         <= 1'b1;
                            state_q       <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign ready_o    = ready_q;
    assign rdata_o    = rdata_q;
    assign fu_valid_o = fu_valid_q;
    assign fu_addr_o  = fu_addr_q;
    assign fu_wdata_o = fu_wdata_q;
    assign fu_wstrb_o = fu_wstrb_q;
    assign fu_run_o   = fu_run_q;
    assign fu_clear_o = fu_clear_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_xversat_ctrl.sv
// Directed bench for xversat_ctrl: read results go through an expected-value queue,
// run/irq pulses are counted by a negedge monitor.
module tb_xversat_ctrl;

    localparam logic [31:0] CTRL = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] addr = '0;
    logic        wstrb = 1'b0;
    logic [31:0] wdata = '0;
    logic [1:0]  fu_done = 2'b00;

    logic        ready_o;
    logic [31:0] rdata_o;
    logic [1:0]  fu_valid_o;
    logic [7:0]  fu_addr_o;
    logic [31:0] fu_wdata_o;
    logic        fu_wstrb_o;
    logic        fu_run_o;
    logic        fu_clear_o;
    logic        irq_o;

    xversat_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid),
        .addr_i     (addr),
        .wstrb_i    (wstrb),
        .wdata_i    (wdata),
        .ready_o    (ready_o),
        .rdata_o    (rdata_o),
        .fu_valid_o (fu_valid_o),
        .fu_addr_o  (fu_addr_o),
        .fu_wdata_o (fu_wdata_o),
        .fu_wstrb_o (fu_wstrb_o),
        .fu_run_o   (fu_run_o),
        .fu_clear_o (fu_clear_o),
        .fu_done_i  (fu_done),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    int cyc     = 0;
    int run_cnt = 0;
    int irq_cnt = 0;
    int run_t[$];

    logic [31:0] exp_q[$];
    string       tag_q[$];

    logic [1:0]  s_valid;
    logic [7:0]  s_addr;
    logic [31:0] s_wdata;
    logic        s_wstrb;
    logic        s_clear;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (fu_run_o) begin
            run_cnt++;
            run_t.push_back(cyc);
        end
        if (irq_o) irq_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d);
        bit got = 1'b0;
        valid = 1'b1;
        addr  = a;
        wstrb = w;
        wdata = d;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            if (ready_o) got = 1'b1;
        end
        if (!got) begin
            chk("bus_ready", ready_o, 1'b1);
            if (!w) begin
                void'(exp_q.pop_front());
                void'(tag_q.pop_front());
            end
        end else begin
            s_valid = fu_valid_o;
            s_addr  = fu_addr_o;
            s_wdata = fu_wdata_o;
            s_wstrb = fu_wstrb_o;
            s_clear = fu_clear_o;
            if (!w) chk(tag_q.pop_front(), rdata_o, exp_q.pop_front());
        end
        valid = 1'b0;
        wstrb = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        bus(a, 1'b0, '0);
    endtask

    task automatic wait_run(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (fu_run_o) got = 1'b1;
        end
        chk(tag, fu_run_o, 1'b1);
    endtask

    initial begin
        int base_run;
        int base_irq;
        int base_idx;
        int min_gap;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_outputs", {ready_o, rdata_o, fu_valid_o, fu_addr_o, fu_wdata_o,
                            fu_wstrb_o, fu_run_o, fu_clear_o, irq_o}, '0);
        rst = 1'b0;
        @(negedge clk);
        rd(CTRL + 3, 32'h0000_0001, "rst_status");
        rd(CTRL + 2, 32'h0000_0003, "rst_mask");
        rd(CTRL + 4, 32'h0, "rst_cycles");
        rd(CTRL + 5, 32'h0, "rst_runs");

        // FU region write and read
        bus(32'h4000_002A, 1'b1, 32'h55);
        chk("fu_wr_valid", s_valid, 2'b10);
        chk("fu_wr_addr", s_addr, 8'h2A);
        chk("fu_wr_wdata", s_wdata, 32'h55);
        chk("fu_wr_wstrb", s_wstrb, 1'b1);
        @(negedge clk);
        chk("fu_valid_drop", fu_valid_o, 2'b00);
        rd(32'h0000_0011, 32'h0, "fu_rd_zero");
        chk("fu_rd_valid", s_valid, 2'b01);
        chk("fu_rd_wstrb", s_wstrb, 1'b0);
        chk("fu_rd_addr", s_addr, 8'h11);

        // single run, done returns 10 cycles after fu_run
        fu_done  = 2'b11;
        base_run = run_cnt;
        base_irq = irq_cnt;
        bus(CTRL + 0, 1'b1, '0);
        wait_run("run1_launch");
        fu_done = 2'b00;
        repeat (10) @(negedge clk);
        chk("run1_irq_early", irq_o, 1'b0);
        fu_done = 2'b11;
        @(negedge clk);
        chk("run1_irq", irq_o, 1'b1);
        @(negedge clk);
        chk("run1_irq_drop", irq_o, 1'b0);
        chk("run1_runs_pulses", run_cnt - base_run, 1);
        chk("run1_irq_pulses", irq_cnt - base_irq, 1);
        rd(CTRL + 4, 32'd11, "run1_cycles");
        rd(CTRL + 5, 32'd1, "run1_runs");
        rd(CTRL + 3, 32'h0003_0001, "run1_status");

        // six RUN writes while busy: one active, four queued, one dropped
        fu_done  = 2'b00;
        base_run = run_cnt;
        base_irq = irq_cnt;
        base_idx = run_t.size();
        for (int k = 0; k < 6; k++) bus(CTRL + 0, 1'b1, '0);
        rd(CTRL + 3, 32'h0000_0406, "burst_status_busy");
        fu_done = 2'b11;
        for (int i = 0; i < 100 && irq_cnt < base_irq + 5; i++) @(negedge clk);
        repeat (8) @(negedge clk);
        chk("burst_runs_pulses", run_cnt - base_run, 5);
        chk("burst_irq_pulses", irq_cnt - base_irq, 5);
        min_gap = 1000;
        for (int i = base_idx + 1; i < run_t.size(); i++) begin
            if (run_t[i] - run_t[i-1] < min_gap) min_gap = run_t[i] - run_t[i-1];
        end
        chk("burst_min_gap", min_gap, 4);
        rd(CTRL + 5, 32'd6, "burst_runs");
        rd(CTRL + 4, 32'd3, "burst_cycles");
        rd(CTRL + 3, 32'h0003_0005, "burst_status_ovf");

        // CLEAR drops the sticky overflow
        bus(CTRL + 1, 1'b1, '0);
        chk("clr_pulse", s_clear, 1'b1);
        rd(CTRL + 3, 32'h0003_0001, "clr_status");

        // mask out FU1, which never reports done
        bus(CTRL + 2, 1'b1, 32'h1);
        rd(CTRL + 2, 32'h1, "mask_rd");
        fu_done  = 2'b00;
        base_irq = irq_cnt;
        bus(CTRL + 0, 1'b1, '0);
        wait_run("mask_launch");
        fu_done = 2'b01;
        for (int i = 0; i < 20 && irq_cnt == base_irq; i++) @(negedge clk);
        chk("mask_irq", irq_cnt - base_irq, 1);
        rd(CTRL + 4, 32'd3, "mask_cycles");
        rd(CTRL + 5, 32'd7, "mask_runs");

        // full mask: the same done pattern leaves the run hanging
        bus(CTRL + 2, 1'b1, 32'h3);
        base_irq = irq_cnt;
        bus(CTRL + 0, 1'b1, '0);
        wait_run("hang_launch");
        repeat (20) @(negedge clk);
        rd(CTRL + 3, 32'h0001_0002, "hang_status");

        // CLEAR mid-WAIT with two runs pending
        bus(CTRL + 0, 1'b1, '0);
        bus(CTRL + 0, 1'b1, '0);
        rd(CTRL + 3, 32'h0001_0202, "pend2_status");
        base_run = run_cnt;
        bus(CTRL + 1, 1'b1, '0);
        chk("abort_clear", s_clear, 1'b1);
        rd(CTRL + 3, 32'h0001_0001, "abort_status");
        repeat (10) @(negedge clk);
        chk("abort_no_irq", irq_cnt - base_irq, 0);
        chk("abort_no_run", run_cnt - base_run, 0);
        rd(CTRL + 4, 32'd3, "abort_cycles");
        rd(CTRL + 5, 32'd7, "abort_runs");

        // async reset during WAIT
        bus(CTRL + 2, 1'b1, 32'h1);
        fu_done = 2'b00;
        bus(CTRL + 0, 1'b1, '0);
        wait_run("rstmid_launch");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_outputs", {ready_o, rdata_o, fu_valid_o, fu_addr_o, fu_wdata_o,
                               fu_wstrb_o, fu_run_o, fu_clear_o, irq_o}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base_run = run_cnt;
        repeat (10) @(negedge clk);
        chk("rstmid_no_run", run_cnt - base_run, 0);
        rd(CTRL + 2, 32'h3, "rstmid_mask");
        rd(CTRL + 3, 32'h0000_0001, "rstmid_status");
        rd(CTRL + 4, 32'h0, "rstmid_cycles");
        rd(CTRL + 5, 32'h0, "rstmid_runs");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/xversat_ctrl.md
# xversat_ctrl

Parametrised run/configuration controller for the Versat datapath: decodes the CPU native interface into per-FU configuration requests for `N_FU` functional units and provides a control register bank. It queues run commands and issues a single-cycle global run per queued command. It aggregates masked FU done signals, measures run duration, and raises a completion interrupt. It sits between the CPU bus and the `xyolo_read`/`xyolo_write`-style FUs, replacing fixed two-slave decode and bare done-AND logic.

## Interface
- `ADDR_W`, 32: CPU address width.
- `DATA_W`, 32: CPU data width; must be ≥ 16+`N_FU`.
- `N_FU`, 2: number of FUs, 1..16; `SEL_W` = max(1, clog2(`N_FU`)).
- `FU_ADDR_W`, 8: FU-local config address width.
- `Q_DEPTH`, 4: maximum pending run commands; `QC_W` = clog2(`Q_DEPTH`+1).
- `CNT_W`, 32: cycle and run counter width, ≤ `DATA_W`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `valid` in 1: CPU request; held until `ready`.
- `addr` in `ADDR_W`: CPU address.
- `wstrb` in 1: 1 = write, 0 = read.
- `wdata` in `DATA_W`: write data.
- `ready` out 1: one-cycle acknowledge.
- `rdata` out `DATA_W`: read data, valid while `ready`=1.
- `fu_valid` out `N_FU`: registered one-hot FU config strobe.
- `fu_addr` out `FU_ADDR_W`: registered FU-local address, shared by all FUs.
- `fu_wdata` out `DATA_W`: registered write data, shared.
- `fu_wstrb` out 1: registered write flag, shared.
- `fu_run` out 1: global run pulse.
- `fu_clear` out 1: global clear pulse.
- `fu_done` in `N_FU`: per-FU done level.
- `irq` out 1: one-cycle run-complete pulse.

## Operation
- Accept condition: `accept` = `valid` & ~`ready`. `ready` <= `accept`, so each request is acted on exactly once.
- `addr[ADDR_W-1]`=0 selects the FU region, with `sel` = `addr[ADDR_W-2 -: SEL_W]`.
  - On accept, `fu_valid[sel]`, `fu_addr` = `addr[FU_ADDR_W-1:0]`, `fu_wdata` and `fu_wstrb` are registered and held for one cycle.
  - If `sel` ≥ `N_FU`, no strobe is issued, but `ready` is still given. FU-region reads return 0.
- `addr[ADDR_W-1]`=1 selects the control region, with the register selected by `addr[2:0]`:
  - 0 RUN (write-only): enqueue one run. If pending = `Q_DEPTH`, the command is dropped and sticky `ovf`=1.
  - 1 CLEAR (write-only): `fu_clear` pulses one cycle; pending=0, `ovf`=0, FSM forced to IDLE with no `irq`; `cycles_last` is unchanged.
  - 2 MASK (read/write): `mask[N_FU-1:0]`, reset value all ones. A FU counts as done if `fu_done[i]` | ~`mask[i]`.
  - 3 STATUS (read): bit0 `idle` (IDLE & pending=0), bit1 busy, bit2 `ovf`, bits[8 +: `QC_W`] pending, bits[16 +: `N_FU`] raw `fu_done`.
  - 4 CYCLES (read): `cycles_last`.
  - 5 RUNS (read): completed-run count, wraps modulo 2^`CNT_W`.
  - Reads of write-only or unused registers return 0. Writes to read-only registers are ignored.
- Pending counter: enqueue and pop in the same cycle leaves the count unchanged.
- FSM:
  - IDLE: if pending > 0, pop and go to LAUNCH.
  - LAUNCH: `fu_run`=1; counter=1; go to GUARD.
  - GUARD: counter+1; `fu_done` is ignored (FUs drop done the cycle after run); go to WAIT.
  - WAIT: counter+1 each cycle. When all masked FUs are done: `cycles_last` <= counter value including this cycle, RUNS+1, `irq`=1, go to IDLE.
- Counter wraps modulo 2^`CNT_W`. With mask=0, the run completes on the first WAIT cycle.

## Timing
- Reset values: `ready`, `rdata`, `fu_valid`, `fu_wstrb`, `fu_run`, `fu_clear`, `irq` = 0. `fu_addr`, `fu_wdata` = 0. FSM in IDLE; pending, `ovf`, `cycles_last`, RUNS = 0; mask all ones.
- Request latency: `ready`/`rdata`/`fu_*` are asserted in the cycle after accept (cycle A+1).
- `fu_run` timing:
  - Idle system: `fu_run` is asserted at A+2 after a RUN write accepted at A.
  - Back-to-back queued runs: minimum spacing is 4 cycles (LAUNCH, GUARD, WAIT, IDLE).
- `cycles_last` = cycles from the `fu_run` cycle to the done-sample cycle, both inclusive; minimum 3.
- `irq` is asserted in the cycle after the done sample.
- `fu_clear` is asserted at A+1. A CLEAR during LAUNCH/GUARD/WAIT aborts the run; the `fu_run` already issued is not retracted.
- Asynchronous `rst` mid-run returns all state to reset values immediately.

## Test plan
- Write FU region, `sel`=1, `addr[7:0]`=0x2A, `wdata`=0x55 -> at A+1: `fu_valid`=0b10, `fu_addr`=0x2A, `fu_wdata`=0x55, `ready`=1. With `sel`=3 and `N_FU`=2 -> `fu_valid`=0, `ready`=1.
- RUN with `fu_done` dropping after run and rising 10 cycles after `fu_run` -> one `fu_run` pulse, `irq` one cycle, CYCLES=11, RUNS=1, STATUS bit0=1.
- 6 RUN writes while busy, `Q_DEPTH`=4 -> 1 active run + 4 queued, `ovf`=1, exactly 5 `fu_run` pulses, each ≥4 cycles apart, RUNS=5.
- mask=0b01, `fu_done`=0b01, FU1 never done -> completes; CYCLES=3 if FU0 done on the first WAIT cycle. mask=0b11 -> stays busy.
- CLEAR mid-WAIT with 2 runs pending -> `fu_clear` pulse, IDLE, pending=0, `ovf`=0, no `irq`, CYCLES unchanged.
- Assert `rst` during WAIT -> all outputs 0, mask=all ones, no `fu_run` after release.
